// File: rtl/audio_record_ctrl.sv
// Audio capture to flash: packs 8-bit samples into 32-bit words and writes them over Avalon-MM.
// Optional AUDIO_REC_SIGN_CONV_EN converts two's-complement samples to offset binary.
module audio_record_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_rate_clk,
  input  logic        start,
  input  logic [7:0]  inData,
  input  logic [23:0] start_address,
  input  logic [23:0] end_address,
  output logic        write,
  output logic [22:0] address,
  output logic [31:0] writeData,
  output logic [3:0]  byteEnable,
  input  logic        waitRequest,
  output logic        overflow,
  output logic        finish
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECORD, DRAIN} state_t;
  typedef struct packed {
    logic [21:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } word_t;

  state_t      state, next_state;
  logic [2:0]  start_sync, src_sync;
  logic        start_edge, tick;
  logic [23:0] byte_address, end_addr;
  logic [31:0] pack_data, pack_next;
  logic [3:0]  mask, mask_next;
  logic [1:0]  lane;
  logic [7:0]  sample;
  logic        push, push_ok, pop, full;
  word_t       mem [FIFO_DEPTH];
  word_t       head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Two synchronizer flops plus one history flop for the edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync <= '0;
      src_sync   <= '0;
    end else begin
      start_sync <= {start_sync[1:0], start};
      src_sync   <= {src_sync[1:0], sample_rate_clk};
    end
  end
  assign start_edge = start_sync[1] & ~start_sync[2];
  assign tick       = src_sync[1] & ~src_sync[2];

`ifdef AUDIO_REC_SIGN_CONV_EN
  assign sample = {~inData[7], inData[6:0]};
`else
  assign sample = inData;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge && end_address >= start_address) next_state = RECORD;
      RECORD:  if (tick && byte_address == end_addr) next_state = DRAIN;
      DRAIN:   if (count == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    lane      = byte_address[1:0];
    pack_next = pack_data;
    pack_next[{lane, 3'b000} +: 8] = sample;
    mask_next = mask | (4'b0001 << lane);
  end

  assign push    = (state == RECORD) && tick && (lane == 2'd3 || byte_address == end_addr);
  assign pop     = (count != '0) && !waitRequest;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_address <= '0;
      end_addr     <= '0;
      pack_data    <= '0;
      mask         <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      if (state == IDLE && start_edge) begin
        byte_address <= start_address;
        end_addr     <= end_address;
        pack_data    <= '0;
        mask         <= '0;
        overflow     <= 1'b0;
      end
      if (state == RECORD && tick) begin
        byte_address <= byte_address + 24'd1;
        if (push) begin
          pack_data <= '0;
          mask      <= '0;
        end else begin
          pack_data <= pack_next;
          mask      <= mask_next;
        end
      end
      if (push_ok) begin
        mem[wr_ptr] <= '{waddr: byte_address[23:2], data: pack_next, mask: mask_next};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (push && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bus fields come straight from the FIFO storage flops; idle bus reads as zero.
  assign head       = mem[rd_ptr];
  assign write      = (count != '0);
  assign address    = write ? {1'b0, head.waddr} : '0;
  assign writeData  = write ? head.data : '0;
  assign byteEnable = write ? head.mask : '0;
  assign finish     = (state == IDLE);
endmodule

// File: tb/tb_audio_record_ctrl.sv
// Bench for audio_record_ctrl: constant vectors, corner sequences, and randomized captures
// checked against a word-grouping reference model.
module tb_audio_record_ctrl;
  logic        clk = 0, reset = 1, sample_rate_clk = 0, start = 0, waitRequest = 0;
  logic [7:0]  inData = 0;
  logic [23:0] start_address = 0, end_address = 0;
  logic        write, overflow, finish;
  logic [22:0] address;
  logic [31:0] writeData;
  logic [3:0]  byteEnable;

  audio_record_ctrl #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .sample_rate_clk(sample_rate_clk), .start(start),
    .inData(inData), .start_address(start_address), .end_address(end_address),
    .write(write), .address(address), .writeData(writeData), .byteEnable(byteEnable),
    .waitRequest(waitRequest), .overflow(overflow), .finish(finish));

  always #5 clk = ~clk;

  typedef struct packed { logic [22:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  typedef struct packed {
    logic [23:0] s, e; logic [3:0] n; logic [7:0][7:0] d;
    logic [1:0] nw; logic [1:0][22:0] a; logic [1:0][31:0] w; logic [1:0][3:0] be;
  } vec_t;

  int checks = 0, errors = 0;
  int wr_mode = 0;  // 0: never stall, 1: always stall, 2: random stall
  wr_t got_q[$], exp_q[$];
  logic [7:0] smp_q[$];
  logic hold = 0;
  wr_t  held;
  vec_t vt [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: drives waitRequest, logs accepted writes, checks outputs hold while stalled.
  always @(negedge clk) begin
    case (wr_mode)
      0:       waitRequest = 1'b0;
      1:       waitRequest = 1'b1;
      default: waitRequest = ($urandom_range(0, 3) == 0);
    endcase
    if (reset) hold = 0;
    else begin
      if (hold) check("hold_stable", {address, writeData, byteEnable}, held);
      if (write && !waitRequest) got_q.push_back({address, writeData, byteEnable});
      hold = write && waitRequest;
      held = {address, writeData, byteEnable};
    end
  end

  function automatic logic [7:0] conv(input logic [7:0] x);
`ifdef AUDIO_REC_SIGN_CONV_EN
    return x ^ 8'h80;
`else
    return x;
`endif
  endfunction

  // Reference: every byte address s..e lands in word a/4, lane a%4; one write per distinct word.
  task automatic build_exp(input logic [23:0] s, input logic [23:0] e);
    wr_t t;
    logic [23:0] a;
    exp_q.delete();
    for (int i = 0; i <= int'(e - s); i++) begin
      a = s + 24'(i);
      if (exp_q.size() == 0 || exp_q[exp_q.size()-1].a != 23'(a / 4))
        exp_q.push_back('{a: 23'(a / 4), d: 32'h0, be: 4'h0});
      t = exp_q[exp_q.size()-1];
      t.d = t.d | (32'(conv(smp_q[i])) << (8 * (a % 4)));
      t.be[a % 4] = 1'b1;
      exp_q[exp_q.size()-1] = t;
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic pulse_start(input logic [23:0] s, input logic [23:0] e);
    @(negedge clk);
    start_address = s; end_address = e; start = 1;
    repeat (5) @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_sample(input logic [7:0] d);
    @(negedge clk);
    inData = d; sample_rate_clk = 1;
    repeat (4) @(negedge clk);
    sample_rate_clk = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while (!finish && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(finish), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_write(input string name);
    int n = 0;
    while (!write && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(write), 64'd1);
  endtask

  task automatic run_capture(input string name, input logic [23:0] s, input logic [23:0] e);
    got_q.delete();
    build_exp(s, e);
    pulse_start(s, e);
    check({name, "_busy"}, 64'(finish), 64'd0);
    foreach (smp_q[i]) send_sample(smp_q[i]);
    wait_finish({name, "_finish"});
    compare_writes(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '0; vt[0].s = 24'h000100; vt[0].e = 24'h000107; vt[0].n = 8;
    vt[0].d = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
    vt[0].nw = 2; vt[0].a = {23'h41, 23'h40};
    vt[0].w = {32'h18171615, 32'h14131211}; vt[0].be = {4'b1111, 4'b1111};
    vt[1] = '0; vt[1].s = 24'h000102; vt[1].e = 24'h000105; vt[1].n = 4;
    vt[1].d = {32'h0, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
    vt[1].nw = 2; vt[1].a = {23'h41, 23'h40};
    vt[1].w = {32'h0000A4A3, 32'hA2A10000}; vt[1].be = {4'b0011, 4'b1100};
    vt[2] = '0; vt[2].s = 24'h000003; vt[2].e = 24'h000003; vt[2].n = 1;
    vt[2].d = {56'h0, 8'h80}; vt[2].nw = 1; vt[2].a = {23'h0, 23'h0}; vt[2].be = {4'b0, 4'b1000};
`ifdef AUDIO_REC_SIGN_CONV_EN
    vt[2].w = {32'h0, 32'h00000000};
`else
    vt[2].w = {32'h0, 32'h80000000};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_write", 64'(write), 0);
    check("rst_address", 64'(address), 0);
    check("rst_wdata", 64'(writeData), 0);
    check("rst_be", 64'(byteEnable), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_finish", 64'(finish), 1);
    reset = 0;
    repeat (3) @(negedge clk);

    // Constant vectors
    for (int v = 0; v < 3; v++) begin
      got_q.delete();
      pulse_start(vt[v].s, vt[v].e);
      for (int i = 0; i < int'(vt[v].n); i++) send_sample(vt[v].d[i]);
      wait_finish("vec_finish");
      check("vec_count", 64'(got_q.size()), 64'(vt[v].nw));
      for (int i = 0; i < int'(vt[v].nw) && i < got_q.size(); i++) begin
        check("vec_addr", 64'(got_q[i].a), 64'(vt[v].a[i]));
        check("vec_data", 64'(got_q[i].d), 64'(vt[v].w[i]));
        check("vec_be", 64'(got_q[i].be), 64'(vt[v].be[i]));
      end
    end

    // Long stall on the first word
    smp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    got_q.delete();
    build_exp(24'h000100, 24'h000107);
    wr_mode = 1;
    pulse_start(24'h000100, 24'h000107);
    for (int i = 0; i < 4; i++) send_sample(smp_q[i]);
    wait_write("stall_wait");
    repeat (20) @(negedge clk);
    check("stall_no_accept", 64'(got_q.size()), 0);
    wr_mode = 0;
    for (int i = 4; i < 8; i++) send_sample(smp_q[i]);
    wait_finish("stall_finish");
    compare_writes("stall");

    // Overflow with a depth-2 FIFO and a stuck slave
    smp_q.delete();
    for (int i = 0; i < 16; i++) smp_q.push_back(8'(8'h30 + i));
    got_q.delete();
    build_exp(24'h000200, 24'h00020F);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    wr_mode = 1;
    pulse_start(24'h000200, 24'h00020F);
    foreach (smp_q[i]) send_sample(smp_q[i]);
    check("ovf_set", 64'(overflow), 1);
    check("ovf_none_accepted", 64'(got_q.size()), 0);
    wr_mode = 0;
    wait_finish("ovf_finish");
    compare_writes("ovf");
    check("ovf_sticky", 64'(overflow), 1);
    got_q.delete();
    pulse_start(24'h000300, 24'h0002FF);
    repeat (10) @(negedge clk);
    check("bad_range_ovf_clr", 64'(overflow), 0);
    check("bad_range_idle", 64'(finish), 1);
    check("bad_range_nowrite", 64'(got_q.size()), 0);

    // Asynchronous reset mid-stall
    smp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    wr_mode = 1;
    pulse_start(24'h000100, 24'h000107);
    for (int i = 0; i < 4; i++) send_sample(smp_q[i]);
    wait_write("rst_mid_wait");
    #2 reset = 1;
    #1;
    check("rst_mid_write", 64'(write), 0);
    check("rst_mid_finish", 64'(finish), 1);
    repeat (2) @(negedge clk);
    reset = 0;
    wr_mode = 0;
    repeat (2) @(negedge clk);
    run_capture("after_rst", 24'h000100, 24'h000107);

    // Randomized captures against the model
    wr_mode = 2;
    for (int k = 0; k < 9; k++) begin
      logic [23:0] s, e;
      int len;
      len = $urandom_range(1, 10);
      s = (k == 8) ? 24'hFFFFFA : 24'($urandom_range(0, 32'h00FFFFF0));
      e = (k == 8) ? 24'hFFFFFF : s + 24'(len - 1);
      smp_q.delete();
      for (int i = 0; i <= int'(e - s); i++) smp_q.push_back(8'($urandom));
      run_capture("rand", s, e);
    end
    wr_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
